// File: rtl/spi_slave_burst_if.sv
// Bus bundle between the SPI slave front-end and its master side: serial
// pins plus the parallel handshake towards the memory/register wrapper.
interface spi_slave_burst_if #(
  parameter int DATA_W = 8
);
  localparam int RX_W = DATA_W + 2;

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [RX_W-1:0]   rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ack;
  logic              frame_err;
  logic              rd_pending;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, tx_ack, frame_err, rd_pending
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, tx_ack, frame_err, rd_pending
  );
endinterface

// File: rtl/spi_slave_burst.sv
// SPI slave front-end: deserialises a command bit plus an RX_W-bit word per
// SS_n frame, and serialises wrapper read data on MISO with gap-free bursts
// of up to MAX_BURST words. Aborted receive frames raise frame_err.
module spi_slave_burst #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_burst_if.slave  bus
);
  localparam int RX_W  = DATA_W + 2;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int WC_W  = $clog2(MAX_BURST + 1);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RX_W);
  localparam logic [WC_W-1:0]  WC_MAX    = WC_W'(MAX_BURST);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_TX
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;        // received payload bits, saturates at RX_W
  logic [WC_W-1:0]   word_cnt;   // words served this frame, saturates at MAX_BURST
  logic [BIT_W-1:0]  bits_left;  // bits still to drive from tx_shift
  logic [DATA_W-2:0] tx_shift;   // remaining bits of the word on MISO
  logic [CNT_W-1:0]  rx_idx;

  // Payload arrives MSB first, so bit cnt lands at position RX_W-1-cnt.
  assign rx_idx = CNT_LAST - cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; SS_n high always falls back to IDLE.
  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      IDLE:      if (!bus.SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (bus.SS_n)          next_state = IDLE;
        else if (!bus.MOSI)    next_state = WRITE;
        else if (bus.rd_pending) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD: if (bus.SS_n) next_state = IDLE;
      READ_DATA: begin
        if (bus.SS_n)              next_state = IDLE;
        else if (cnt == CNT_LAST)  next_state = READ_TX;
      end
      READ_TX:   if (bus.SS_n) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Receive shifter, transmit shifter, handshake pulses and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, including the shifter, takes the async
    // reset so a reset mid-frame leaves no stale data driving MISO.
    if (!rst_n) begin
      bus.MISO       <= 1'b0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.tx_ack     <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.rd_pending <= 1'b0;
      cnt            <= '0;
      word_cnt       <= '0;
      bits_left      <= '0;
      tx_shift       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values regardless of statement order.
      bus.rx_valid  <= 1'b0;
      bus.tx_ack    <= 1'b0;
      bus.frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.MISO  <= 1'b0;
          cnt       <= '0;
          word_cnt  <= '0;
          bits_left <= '0;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bus.SS_n) begin
            // Frame closed before the word was complete.
            if (cnt != CNT_FULL) bus.frame_err <= 1'b1;
          end else if (cnt != CNT_FULL) begin
            bus.rx_data[rx_idx] <= bus.MOSI;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              bus.rx_valid <= 1'b1;
              if (state == READ_ADD) bus.rd_pending <= 1'b1;
            end
          end
        end
        READ_TX: begin
          if (bus.SS_n) begin
            // Master ended the frame: drop whatever is left of the word.
            bus.MISO  <= 1'b0;
            bits_left <= '0;
          end else if (bits_left != '0) begin
            bus.MISO  <= tx_shift[DATA_W-2];
            tx_shift  <= tx_shift << 1;
            bits_left <= bits_left - 1'b1;
          end else if (bus.tx_valid && word_cnt != WC_MAX) begin
            bus.MISO       <= bus.tx_data[DATA_W-1];
            tx_shift       <= bus.tx_data[DATA_W-2:0];
            bits_left      <= BITS_LAST;
            bus.tx_ack     <= 1'b1;
            bus.rd_pending <= 1'b0;
            word_cnt       <= word_cnt + 1'b1;
          end else begin
            bus.MISO <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_burst.sv
// Self-checking bench for spi_slave_burst: an 8-bit instance for the
// write/read/burst/abort/reset scenarios and a 16-bit instance for width.
module tb_spi_slave_burst;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spi_slave_burst_if #(.DATA_W(8))  bus();
  spi_slave_burst_if #(.DATA_W(16)) bus16();

  spi_slave_burst #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  spi_slave_burst #(.DATA_W(16), .MAX_BURST(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_rx[$];
  logic [31:0] exp_rx16[$];
  bit          exp_miso[$];
  int          miso_left = 0;
  int          ack_cnt   = 0;
  int          err_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Received words are compared against the scoreboard as they complete.
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid) begin
      if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
      else check("rx_data", 32'(bus.rx_data), exp_rx.pop_front());
    end
    if (rst_n && bus16.rx_valid) begin
      if (exp_rx16.size() == 0) check("rx16_unexpected", 1, 0);
      else check("rx16_data", 32'(bus16.rx_data), exp_rx16.pop_front());
    end
  end

  // MISO bits are compared for DATA_W cycles starting at each tx_ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      miso_left = 0;
    end else begin
      if (bus.frame_err) err_cnt++;
      if (bus.tx_ack) begin
        ack_cnt++;
        check("ack_overlap", miso_left, 0);
        miso_left = 8;
      end
      if (miso_left > 0) begin
        if (exp_miso.size() == 0) check("miso_unexpected", 1, 0);
        else check("miso", 32'(bus.MISO), 32'(exp_miso.pop_front()));
        miso_left--;
      end
    end
  end

  task automatic drive(input bit sel16, input logic ss, input logic mosi);
    @(negedge clk);
    if (sel16) begin bus16.SS_n = ss; bus16.MOSI = mosi; end
    else       begin bus.SS_n   = ss; bus.MOSI   = mosi; end
  endtask

  // SS_n low (edge k), command bit (k+1), then nbits payload MSB first.
  task automatic send_frame(input bit sel16, input logic cmd, input logic [31:0] word, input int nbits);
    drive(sel16, 1'b0, 1'b0);
    drive(sel16, 1'b0, cmd);
    for (int i = nbits - 1; i >= 0; i--) drive(sel16, 1'b0, word[i]);
  endtask

  task automatic end_frame(input bit sel16);
    drive(sel16, 1'b1, 1'b0);
    drive(sel16, 1'b1, 1'b0);
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_miso.push_back(w[i]);
  endtask

  task automatic wait_ack(input string tag, output int waited);
    bit seen = 0;
    waited = 0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (bus.tx_ack) seen = 1;
    end
    if (!seen) check(tag, 0, 1);
  endtask

  // Completion checks at the negedge after the last payload bit.
  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.rx_valid), 1);
    check({tag, "_err"}, 32'(bus.frame_err), 0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.rx_valid), 0);
  endtask

  initial begin
    int w;
    int acks0;
    logic [7:0] burst_words[5];
    burst_words = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hFF};

    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_data = '0; bus.tx_valid = 1'b0;
    bus16.SS_n = 1'b1; bus16.MOSI = 1'b0; bus16.tx_data = '0; bus16.tx_valid = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_miso", 32'(bus.MISO), 0);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_tx_ack", 32'(bus.tx_ack), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    check("rst_rd_pending", 32'(bus.rd_pending), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write frame.
    exp_rx.push_back(32'h0A5);
    send_frame(0, 1'b0, 32'h0A5, 10);
    check_done("wr");
    end_frame(0);

    // Read address sets rd_pending.
    exp_rx.push_back(32'h203);
    send_frame(0, 1'b1, 32'h203, 10);
    @(negedge clk);
    check("ra_valid", 32'(bus.rx_valid), 1);
    check("ra_pending", 32'(bus.rd_pending), 1);
    end_frame(0);

    // Read data: one word 0xC3, earliest latency.
    acks0 = ack_cnt;
    bus.tx_data = 8'hC3; bus.tx_valid = 1'b1;
    push_word(8'hC3);
    exp_rx.push_back(32'h3C5);
    send_frame(0, 1'b1, 32'h3C5, 10);
    @(negedge clk);
    check("rd_valid", 32'(bus.rx_valid), 1);
    check("rd_no_early_ack", 32'(bus.tx_ack), 0);
    @(negedge clk);
    check("rd_ack", 32'(bus.tx_ack), 1);
    check("rd_pending_clr", 32'(bus.rd_pending), 0);
    bus.tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("rd_miso_idle", 32'(bus.MISO), 0);
    check("rd_ack_count", ack_cnt - acks0, 1);
    end_frame(0);

    // Burst of four words; the fifth is never served.
    exp_rx.push_back(32'h2AA);
    send_frame(0, 1'b1, 32'h2AA, 10);
    end_frame(0);
    acks0 = ack_cnt;
    bus.tx_data = burst_words[0]; bus.tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) push_word(burst_words[i]);
    exp_rx.push_back(32'h3FF);
    send_frame(0, 1'b1, 32'h3FF, 10);
    wait_ack("burst_ack0_timeout", w);
    for (int i = 1; i < 4; i++) begin
      bus.tx_data = burst_words[i];
      wait_ack("burst_ack_timeout", w);
      check("burst_gap", w, 8);
    end
    bus.tx_data = burst_words[4];
    repeat (8) @(negedge clk);
    check("burst_miso_end", 32'(bus.MISO), 0);
    repeat (8) @(negedge clk);
    check("burst_miso_hold", 32'(bus.MISO), 0);
    check("burst_ack_count", ack_cnt - acks0, 4);
    bus.tx_valid = 1'b0;
    end_frame(0);

    // Abort after 5 payload bits with rd_pending set.
    exp_rx.push_back(32'h155);
    send_frame(0, 1'b1, 32'h155, 10);
    end_frame(0);
    acks0 = err_cnt;
    send_frame(0, 1'b0, 32'h1F, 5);
    drive(0, 1'b1, 1'b0);
    @(negedge clk);
    check("abort_err", 32'(bus.frame_err), 1);
    check("abort_no_valid", 32'(bus.rx_valid), 0);
    check("abort_pending", 32'(bus.rd_pending), 1);
    @(negedge clk);
    check("abort_pulse", 32'(bus.frame_err), 0);
    check("abort_err_count", err_cnt - acks0, 1);

    // Reset in the middle of a READ_TX word.
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
    push_word(8'h5A);
    exp_rx.push_back(32'h300);
    send_frame(0, 1'b1, 32'h300, 10);
    wait_ack("rst_ack_timeout", w);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_miso", 32'(bus.MISO), 0);
    check("mid_rst_rx_data", 32'(bus.rx_data), 0);
    check("mid_rst_tx_ack", 32'(bus.tx_ack), 0);
    check("mid_rst_pending", 32'(bus.rd_pending), 0);
    check("mid_rst_err", 32'(bus.frame_err), 0);
    exp_miso.delete();
    bus.SS_n = 1'b1; bus.tx_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    exp_rx.push_back(32'h2C3);
    send_frame(0, 1'b0, 32'h2C3, 10);
    check_done("post_rst_wr");
    check("post_rst_pending", 32'(bus.rd_pending), 0);
    end_frame(0);

    // 16-bit instance: 18-bit write word.
    exp_rx16.push_back(32'h2BEEF);
    send_frame(1, 1'b0, 32'h2BEEF, 18);
    @(negedge clk);
    check("w16_valid", 32'(bus16.rx_valid), 1);
    @(negedge clk);
    check("w16_pulse", 32'(bus16.rx_valid), 0);
    end_frame(1);

    check("rx_queue_left", exp_rx.size(), 0);
    check("rx16_queue_left", exp_rx16.size(), 0);
    check("miso_queue_left", exp_miso.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/spi_slave_burst.md
# spi_slave_burst

Parametrised SPI slave front-end that converts a serial MOSI stream, framed by SS_n, into parallel command/payload words and serialises read data back on MISO. It is the next-generation slave for the SPI subsystem, sitting between the external master and the memory/register wrapper that consumes `rx_data` and supplies `tx_data`. Compared with the first-generation slave it adds:
- configurable data width;
- single-cycle handshake pulses;
- gap-free burst reads;
- explicit detection of aborted frames.

## Interface
- `DATA_W`, default 8: width of the data word returned on MISO. The received word width is `RX_W = DATA_W + 2`, a localparam made of a 2-bit sub-command plus the payload.
- `MAX_BURST`, default 4: maximum number of read words served per READ_DATA frame. Must be at least 1.

Ports (name, direction, width, meaning):
- `clk`, in, 1: serial clock; all logic on its rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `SS_n`, in, 1: slave select, active-low.
- `MOSI`, in, 1: serial data in, MSB first.
- `MISO`, out, 1: serial data out, MSB first.
- `rx_data`, out, `RX_W`: last received word.
- `rx_valid`, out, 1: one-cycle pulse, `rx_data` complete.
- `tx_data`, in, `DATA_W`: read data from the wrapper.
- `tx_valid`, in, 1: `tx_data` valid.
- `tx_ack`, out, 1: one-cycle pulse, `tx_data` consumed.
- `frame_err`, out, 1: one-cycle pulse, frame aborted.
- `rd_pending`, out, 1: a read address has been received and its read data has not yet been served.

## Operation
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, `tx_ack`=0, `frame_err`=0, `rd_pending`=0, state IDLE, all counters 0.
- State machine states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_TX.
- IDLE:
  - `SS_n`=0 goes to CHK_CMD.
  - `rx_data` holds its last value; `MISO`=0; counters are cleared.
- CHK_CMD, with `SS_n`=0, samples the command bit on MOSI:
  - MOSI=0 goes to WRITE.
  - MOSI=1 and `rd_pending`=0 goes to READ_ADD.
  - MOSI=1 and `rd_pending`=1 goes to READ_DATA.
  - `SS_n`=1 goes to IDLE with no error.
- WRITE, READ_ADD and READ_DATA: shift MOSI into `rx_data[RX_W-1-cnt]`, one bit per cycle.
  - When `cnt` reaches `RX_W`, `rx_valid` pulses for exactly one cycle.
  - READ_ADD then sets `rd_pending`=1 and stays in READ_ADD until `SS_n`=1.
  - READ_DATA then moves to READ_TX.
  - WRITE stays in WRITE until `SS_n`=1.
- READ_TX:
  - On an edge with `tx_valid`=1 and the shifter idle: `tx_ack` is 1 for the following cycle, `MISO` takes `tx_data[DATA_W-1]`, the remaining bits are loaded into the shifter, `rd_pending` is cleared, and the word count increments.
  - Following edges drive `tx_data[DATA_W-2]` down to `[0]` on MISO.
  - Burst: at the edge after the last bit, if `tx_valid`=1 and word count < `MAX_BURST`, the next word loads with no gap.
  - Otherwise `MISO` goes to 0 and the block waits. Once `MAX_BURST` words are sent, further `tx_valid` is ignored and `MISO`=0.
- Abort: `SS_n`=1 in WRITE, READ_ADD or READ_DATA before `cnt`=`RX_W` has these effects:
  - `frame_err` pulses for one cycle and `rx_valid` is not asserted.
  - `rd_pending` is unchanged and the state returns to IDLE.
- `SS_n`=1 in READ_TX mid-word goes to IDLE, `MISO` goes to 0 and the rest of the word is dropped, with no `frame_err`. The aborted word still counts as acknowledged.
- In every state other than IDLE, `SS_n`=1 returns to IDLE on the next edge.
- A reset assertion in any state forces all reset values immediately, including clearing `rd_pending`.

## Timing
- Let SS_n be first sampled low at edge k:
  - edge k+1 samples the command bit;
  - edges k+2 to k+1+`RX_W` sample payload bits, MSB first;
  - `rx_valid` is high during the cycle after edge k+1+`RX_W`.
- Read latency: the first MISO bit appears after the first edge at which `tx_valid`=1 in READ_TX. That is at the earliest the edge after the `rx_valid` pulse.
- A burst occupies `DATA_W` cycles per word back-to-back when `tx_valid` is held high.
- Counters are sized `$clog2(RX_W+1)` and `$clog2(MAX_BURST+1)`; they saturate and never wrap.

## Test plan
- Reset mid-READ_TX (rst_n low for 1 cycle) -> all outputs 0, `rd_pending`=0, state IDLE; the next frame decodes normally.
- Write, `DATA_W`=8, SS_n low, MOSI 0 then 10'b00_1010_0101 -> `rx_data`=10'h0A5, `rx_valid` high exactly 1 cycle at edge k+11, `frame_err`=0.
- Read address then read data:
  - Frame 1: bit 1 then 10'b10_0000_0011 -> `rx_valid` pulse, `rd_pending`=1.
  - Frame 2: bit 1 then 10'b11_xxxx_xxxx, then `tx_data`=8'hC3 with `tx_valid` -> `tx_ack` 1 cycle, MISO 1,1,0,0,0,0,1,1, `rd_pending`=0.
- Burst, `MAX_BURST`=4, `tx_valid` held with words 8'h81, 8'h42, 8'h24, 8'h18, 8'hFF -> 32 contiguous MISO bits, 4 `tx_ack` pulses, 8'hFF never shifted, MISO=0 afterwards.
- Abort: SS_n rises after 5 payload bits of a write -> `frame_err` pulse, no `rx_valid`, `rd_pending` unchanged.
- Generic width: `DATA_W`=16, write frame of 18 bits 18'h2BEEF -> `rx_data`=18'h2BEEF, `rx_valid` at edge k+19.
